// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer scanout controller.
package fb_pkg;
  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;

  typedef enum logic [1:0] {WAIT_FRAME, FETCH, DONE} fb_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Bit replication keeps full-scale 7/3 mapping to 0xFF.
  function automatic rgb888_t rgb332_to_rgb888(input logic [7:0] p);
    rgb888_t c;
    c.r = {p[7:5], p[7:5], p[7:6]};
    c.g = {p[4:2], p[4:2], p[4:3]};
    c.b = {4{p[1:0]}};
    return c;
  endfunction
endpackage

// File: rtl/fb_scanout_ctrl_fifo.sv
// Show-ahead prefetch FIFO: head is valid whenever not empty; flush beats push/pop.
module fb_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [DW-1:0]              wdata_i,
  output logic [DW-1:0]              head_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/fb_scanout_ctrl.sv
// Framebuffer scanout sequencer: prefetches RGB332 pixels for the HDMI
// transmitter and hands every spare RAM slot to the host writer.
module fb_scanout_ctrl
  import fb_pkg::*;
#(
  parameter int WIDTH      = FB_WIDTH,
  parameter int HEIGHT     = FB_HEIGHT,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_pixel,
  input  logic              rst,
  input  logic              in_enable,
  input  logic              in_newframe,
  output logic [7:0]        o_red,
  output logic [7:0]        o_green,
  output logic [7:0]        o_blue,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              o_underflow,
  output logic              o_busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0]   NPIX = (ADDR_W+1)'(WIDTH * HEIGHT);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);

  fb_state_e         state_q;
  logic [ADDR_W-1:0] faddr_q;
  logic              rd_pend_q;
  logic              uf_q;

  logic [CW-1:0] fcount;
  logic          fempty;
  logic [7:0]    fhead;
  logic          pop, restart, fetch_issue, wr_fire;
  rgb888_t       pix;

  assign pop         = in_enable && !fempty;
  assign restart     = in_newframe && (state_q == FETCH);
  assign fetch_issue = !rst && (state_q == FETCH) &&
                       ((fcount + CW'(rd_pend_q)) < CW'(FIFO_DEPTH));
  assign wr_ready    = !rst && !fetch_issue;
  assign wr_fire     = wr_valid && wr_ready;

  fb_prefetch_fifo #(.DEPTH(FIFO_DEPTH), .DW(8)) u_fifo (
    .clk     (clk_pixel),
    .rst     (rst),
    .push_i  (rd_pend_q),
    .pop_i   (pop),
    .flush_i (restart),
    .wdata_i (mem_rdata),
    .head_o  (fhead),
    .empty_o (fempty),
    .count_o (fcount)
  );

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (fetch_issue) begin
      mem_addr = faddr_q;
    end else if (wr_fire) begin
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
      mem_we    = ({1'b0, wr_addr} < NPIX);
    end
  end

  assign pix = rgb332_to_rgb888(fhead);
  assign {o_red, o_green, o_blue} = (pop && !rst) ? pix : '0;

  // A read issued in the restart cycle belongs to the aborted frame.
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      state_q   <= WAIT_FRAME;
      faddr_q   <= '0;
      rd_pend_q <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      rd_pend_q <= fetch_issue && !restart;
      if (in_enable && fempty && (state_q != WAIT_FRAME)) uf_q <= 1'b1;
      case (state_q)
        WAIT_FRAME, DONE: begin
          if (in_newframe) begin
            state_q <= FETCH;
            faddr_q <= '0;
          end
        end
        FETCH: begin
          if (in_newframe) begin
            faddr_q <= '0;
            uf_q    <= 1'b1;
          end else if (fetch_issue) begin
            faddr_q <= faddr_q + ADDR_W'(1);
            if (faddr_q == LAST) state_q <= DONE;
          end
        end
        default: state_q <= WAIT_FRAME;
      endcase
    end
  end

  assign o_underflow = uf_q;
  assign o_busy      = (state_q == FETCH);
endmodule

// File: doc/fb_scanout_ctrl.md
Name: fb_scanout_ctrl

Overview:
Sequences framebuffer scanout for the HDMI transmitter and shares a single-port framebuffer RAM between scanout reads and a host write port.
- Prefetches RGB332 pixels into a small FIFO.
- Expands each pixel to 8-bit R/G/B, presented in the same cycle the transmitter asserts its enable.
- Grants the host writer every memory slot that scanout does not need.
- Sits between the framebuffer RAM and the HDMI block, in the pixel clock domain.

Parameters:
WIDTH, 640, active pixels per line
HEIGHT, 480, active lines per frame
ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
FIFO_DEPTH, 4, prefetch FIFO entries (power of two, >= 2)

Ports:
clk_pixel  in  1  pixel clock
rst  in  1  synchronous active-high reset
in_enable  in  1  transmitter active-area strobe; pixel consumed this cycle
in_newframe  in  1  single-cycle pulse on last active pixel of a frame
o_red  out  8  red to transmitter
o_green  out  8  green to transmitter
o_blue  out  8  blue to transmitter
wr_valid  in  1  host write request
wr_ready  out  1  host write accepted this cycle when wr_valid also high
wr_addr  in  ADDR_W  host write address
wr_data  in  8  host RGB332 pixel
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  8  RAM write data
mem_rdata  in  8  RAM read data, valid exactly 1 cycle after a read is issued
o_underflow  out  1  sticky: pixel demanded while FIFO empty
o_busy  out  1  high in FETCH state

Behaviour:
Interface (already decided): one clock, clk_pixel; reset rst is synchronous and active-high.

Reset values:
- o_red/o_green/o_blue = 0, mem_we = 0, mem_addr = 0, o_underflow = 0, o_busy = 0.
- FIFO empty, in-flight count 0, state WAIT_FRAME.

States:
- WAIT_FRAME: no reads issued; in_enable is ignored and never flags underflow. On in_newframe: fetch address := 0, go to FETCH.
- FETCH: fetch is issued when (fifo_count + inflight) < FIFO_DEPTH. Issue = mem_addr = fetch address, mem_we = 0, fetch address += 1. After the read of address WIDTH*HEIGHT-1 is issued, go to DONE.
- DONE: no reads issued. On in_newframe: fetch address := 0, go to FETCH.

Read return:
- Data returning one cycle after an issue is pushed into the FIFO.
- inflight is at most 1 (1-cycle latency), so the FIFO never overflows.

Consumption:
- Output is combinational from the FIFO head: when in_enable && !empty, o_red/o_green/o_blue = expand(head), and head is popped that cycle. Otherwise outputs are 0.
- When in_enable && empty in FETCH or DONE, set o_underflow; it stays set until rst.

Expansion (RGB332 = R[7:5] G[4:2] B[1:0]):
- red = {R,R,R[2:1]}
- green = {G,G,G[2:1]}
- blue = {B,B,B,B}

Arbitration:
- Scanout fetch has absolute priority.
- wr_ready = !rst && !fetch_issue. It depends only on state and occupancy, never on wr_valid.
- On wr_valid && wr_ready: mem_addr = wr_addr, mem_we = 1, mem_wdata = wr_data in the same cycle.
- A write with wr_addr >= WIDTH*HEIGHT is accepted but mem_we stays 0.
- During steady active-area scanout the FIFO drains 1 pixel per cycle, so writes are accepted only in blanking or DONE. This is intended behaviour.

in_newframe while in FETCH (incomplete frame):
- A pop in the same cycle completes first.
- Then flush the FIFO, discard any read returning the next cycle, set o_underflow, set address := 0, stay in FETCH.

Reset mid-operation: everything returns to reset values at the next edge. A read in flight is discarded.

Decomposition:
- Package fb_pkg: state enum (WAIT_FRAME, FETCH, DONE), function rgb332_to_rgb888, default WIDTH/HEIGHT constants.
- Sub-module fb_prefetch_fifo: synchronous FIFO with push, pop, flush, count, and head show-ahead.
- The controller holds the FSM, fetch address, in-flight tracking and arbitration.

Test Plan:
All scenarios use WIDTH=4, HEIGHT=2 (8 pixels) and a behavioural 1-cycle-latency RAM.
1. Reset, then idle: outputs 0, wr_ready=1, o_busy=0. in_enable pulses produce no mem reads and leave o_underflow=0.
2. Pulse in_newframe: reads issue at addresses 0,1,2,3 on consecutive cycles, then stall with the FIFO full. RAM[0]=0xE0 -> on the first in_enable, o_red=0xFF, o_green=0x00, o_blue=0x00.
3. FIFO full with wr_valid=1, wr_addr=5, wr_data=0x1C: wr_ready=1, mem_we=1, mem_addr=5. Then pop one pixel: next cycle the fetch wins and wr_ready=0.
4. Assert in_enable for 8 consecutive cycles after prefetch: 8 pixels out in address order, address 7 is the last read, state DONE, o_underflow stays 0.
5. Assert in_enable with the FIFO empty in FETCH: RGB=0, o_underflow=1, and it stays 1 through a following in_newframe until rst.
6. Pulse in_newframe after 5 fetches: FIFO flushed, next read is address 0, o_underflow=1. Asserting rst the same cycle instead gives all reset values.
